and_event_window_counter: RTL and testbench
===========================================

Name: and_event_window_counter

Overview:
- Downstream consumer of the two-input AND stage's 1-bit output `O`.
- Detects rising edges on that signal and counts them over fixed windows of WINDOW clock cycles.
- At each window close, publishes a saturating count and an overflow flag through a valid/ready output port.
- A one-entry holding register decouples the output from the consumer, with a sticky flag for results dropped under backpressure.

Parameters:
- WIDTH, 8, width of the count result; legal range >= 1.
- WINDOW, 16, window length in clock cycles; legal range >= 2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  1  monitored signal, driven by the AND stage output.
- O_ready  input  1  consumer ready.
- O_valid  output  1  result held and valid.
- O_count  output  WIDTH  rising-edge count for the completed window.
- O_overflow  output  1  count saturated during that window.
- O_dropped  output  1  sticky: a window result was discarded because the holding register was full.

Behaviour:
- Reset (RESET=1 at a CLK edge) clears:
  - i_q (previous-I register) to 0;
  - win_cnt and acc to 0;
  - acc_ovf to 0;
  - O_valid, O_count, O_overflow, O_dropped to 0.
- Reset has priority over every other event, including mid-window and with a result pending. A pending result is lost and does not set O_dropped.
- Edge detect: rise = I & ~i_q, combinational in the current cycle. i_q <= I every cycle.
  - After reset i_q=0, so I=1 in the first cycle counts as a rise.
- Window counter: win_cnt increments 0..WINDOW-1 and wraps to 0. The close cycle is the cycle with win_cnt==WINDOW-1.
- Accumulator, non-close cycle:
  - rise=1 and acc < 2^WIDTH-1: acc <= acc+1.
  - rise=1 and acc == 2^WIDTH-1: acc holds, acc_ovf <= 1.
  - No arithmetic wrap-around ever.
- Close cycle:
  - final = sat(acc + rise); final_ovf = acc_ovf | (rise & acc==max).
  - acc <= 0 and acc_ovf <= 0 unconditionally. A rise in the close cycle belongs to the closing window.
- Output FSM has two states, EMPTY (O_valid=0) and FULL (O_valid=1):
  - EMPTY + close: load O_count/O_overflow with final/final_ovf; go FULL. O_valid rises the cycle after the close cycle (latency 1).
  - FULL + O_ready=1, no close: go EMPTY.
  - FULL + O_ready=1 + close in the same cycle: reload with the new result, stay FULL. No drop.
  - FULL + O_ready=0 + close: keep the old payload, discard the new one, set O_dropped <= 1.
  - FULL + O_ready=0, no close: hold. O_count and O_overflow stay stable while O_valid=1 and O_ready=0.
- O_dropped clears only on RESET.
- O_ready is ignored in EMPTY.
- X on I is not supported; the bench drives known values.

Test Plan:
1. WIDTH=4, WINDOW=8, reset, I=0, O_ready=1 -> O_valid=1 for exactly one cycle, 9 cycles after reset release, with O_count=0, O_overflow=0.
2. WIDTH=4, WINDOW=8, I toggling 1,0,1,0,1,0,1,0 from window start, O_ready=1 -> O_count=4, O_overflow=0. Next window with I=0 -> O_count=0.
3. WIDTH=4, WINDOW=32, I toggling every cycle -> 16 rises, O_count=15, O_overflow=1. The following window's O_overflow=0 if it has <=15 rises.
4. WIDTH=4, WINDOW=8, O_ready=0 across two window closes with 2 then 3 rises:
   - O_count stays 2 and O_dropped=1.
   - Raising O_ready -> one handshake with count 2, then O_valid=0.
5. WIDTH=4, WINDOW=8, I=1 constant from reset, O_ready=1 -> first window O_count=1, all later windows O_count=0. Also a rise exactly on the close cycle counts in the closing window: I=0 except I=1 at win_cnt=7 -> O_count=1.
6. RESET pulsed mid-window with O_valid=1 and acc=3 -> next cycle O_valid=0 and O_dropped=0. The next result appears WINDOW+1 cycles after reset release and counts only post-reset rises.

Source files
------------

// File: rtl/and_event_window_counter.sv
// Counts rising edges of a monitored signal over fixed windows of WINDOW cycles
// and publishes a saturating count plus overflow flag through a one-entry valid/ready holding register.
module and_event_window_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I,
  input  logic             O_ready,
  output logic             O_valid,
  output logic [WIDTH-1:0] O_count,
  output logic             O_overflow,
  output logic             O_dropped
);

  localparam int unsigned CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [CW-1:0] LAST_POS = CW'(WINDOW - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             i_q;
  logic [CW-1:0]    win_cnt;
  logic [WIDTH-1:0] acc;
  logic             acc_ovf;

  logic             rise_c;
  logic             close_c;
  logic             at_max_c;
  logic [WIDTH-1:0] final_count_c;
  logic             final_ovf_c;

  // Closing-window result includes a rise seen in the close cycle itself.
  always_comb begin
    rise_c        = I & ~i_q;
    close_c       = (win_cnt == LAST_POS);
    at_max_c      = (acc == MAX_COUNT);
    final_count_c = (rise_c && !at_max_c) ? acc + 1'b1 : acc;
    final_ovf_c   = acc_ovf | (rise_c & at_max_c);
  end

  assign O_valid = (state == FULL);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= EMPTY;
      i_q        <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      O_count    <= '0;
      O_overflow <= 1'b0;
      O_dropped  <= 1'b0;
    end else begin
      i_q <= I;

      if (close_c) begin
        win_cnt <= '0;
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (rise_c) begin
          if (at_max_c) acc_ovf <= 1'b1;
          else          acc     <= acc + 1'b1;
        end
      end

      // Holding register: a close while full and stalled drops the new result.
      case (state)
        EMPTY: begin
          if (close_c) begin
            O_count    <= final_count_c;
            O_overflow <= final_ovf_c;
            state      <= FULL;
          end
        end
        FULL: begin
          if (O_ready) begin
            if (close_c) begin
              O_count    <= final_count_c;
              O_overflow <= final_ovf_c;
            end else begin
              state <= EMPTY;
            end
          end else if (close_c) begin
            O_dropped <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_and_event_window_counter.sv
// Scoreboard bench: two counters (WINDOW 8 and 32, WIDTH 4) share stimulus and are
// compared against a window-level reference model of rise counts and a one-slot buffer.
module tb_and_event_window_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NDUT  = 2;
  localparam int unsigned MAXC  = 15;

  logic CLK = 1'b0;
  logic RESET;
  logic I;
  logic O_ready;

  logic             o_valid    [NDUT];
  logic [WIDTH-1:0] o_count    [NDUT];
  logic             o_overflow [NDUT];
  logic             o_dropped  [NDUT];

  typedef struct {
    int unsigned cnt;
    bit          ovf;
  } res_t;

  res_t        q      [NDUT][$];
  int unsigned m_pos  [NDUT];
  int unsigned m_rises[NDUT];
  bit          m_prev [NDUT];
  bit          m_occ  [NDUT];
  bit          m_drop [NDUT];
  int unsigned hs     [NDUT];

  int checks = 0;
  int passed = 0;

  and_event_window_counter #(.WIDTH(WIDTH), .WINDOW(8)) dut_w8 (
    .CLK(CLK), .RESET(RESET), .I(I), .O_ready(O_ready),
    .O_valid(o_valid[0]), .O_count(o_count[0]),
    .O_overflow(o_overflow[0]), .O_dropped(o_dropped[0])
  );

  and_event_window_counter #(.WIDTH(WIDTH), .WINDOW(32)) dut_w32 (
    .CLK(CLK), .RESET(RESET), .I(I), .O_ready(O_ready),
    .O_valid(o_valid[1]), .O_count(o_count[1]),
    .O_overflow(o_overflow[1]), .O_dropped(o_dropped[1])
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned win_of(input int k);
    return (k == 0) ? 32'd8 : 32'd32;
  endfunction

  function void check(input string name, input int k, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
  endfunction

  // Reference: total rises per window, saturated at MAXC, fed into a one-slot buffer.
  always @(posedge CLK) begin
    res_t r;
    for (int k = 0; k < NDUT; k++) begin
      if (RESET) begin
        m_prev[k]  = 1'b0;
        m_pos[k]   = 0;
        m_rises[k] = 0;
        m_occ[k]   = 1'b0;
        m_drop[k]  = 1'b0;
        q[k].delete();
      end else begin
        if (I && !m_prev[k]) m_rises[k]++;
        m_prev[k] = I;
        if (m_occ[k] && O_ready) m_occ[k] = 1'b0;
        if (m_pos[k] == win_of(k) - 1) begin
          r.cnt = (m_rises[k] > MAXC) ? MAXC : m_rises[k];
          r.ovf = (m_rises[k] > MAXC);
          if (!m_occ[k]) begin
            q[k].push_back(r);
            m_occ[k] = 1'b1;
          end else begin
            m_drop[k] = 1'b1;
          end
          m_rises[k] = 0;
          m_pos[k]   = 0;
        end else begin
          m_pos[k]++;
        end
      end
    end
  end

  // Monitor: sample away from the active edge, pop on handshake.
  always @(negedge CLK) begin
    for (int k = 0; k < NDUT; k++) begin
      check("valid", k, 32'(o_valid[k]), 32'(m_occ[k]));
      check("dropped", k, 32'(o_dropped[k]), 32'(m_drop[k]));
      if (m_occ[k]) begin
        if (q[k].size() == 0) begin
          check("queue_nonempty", k, 0, 1);
        end else begin
          check("count", k, 32'(o_count[k]), q[k][0].cnt);
          check("overflow", k, 32'(o_overflow[k]), 32'(q[k][0].ovf));
          if (O_ready) begin
            void'(q[k].pop_front());
            hs[k]++;
          end
        end
      end
    end
  end

  task automatic cyc(input bit i, input bit r);
    I = i;
    O_ready = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    I = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    logic [7:0] pat_a;
    logic [7:0] pat_b;
    pat_a = 8'b0000_0101;
    pat_b = 8'b0001_0101;
    for (int k = 0; k < NDUT; k++) hs[k] = 0;
    RESET = 1'b1;
    I = 1'b0;
    O_ready = 1'b1;

    // Idle input: zero-count results.
    do_reset;
    repeat (20) cyc(1'b0, 1'b1);

    // Toggling for one short window, then a quiet window.
    do_reset;
    for (int j = 0; j < 8; j++) cyc(j % 2 == 0, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);

    // Toggling for a long window saturates the WINDOW=32 counter.
    do_reset;
    for (int j = 0; j < 40; j++) cyc(j % 2 == 0, 1'b1);
    repeat (34) cyc(1'b0, 1'b1);

    // Backpressure across two closes (2 then 3 rises), then drain.
    do_reset;
    for (int j = 0; j < 8; j++) cyc(pat_a[j], 1'b0);
    for (int j = 0; j < 8; j++) cyc(pat_b[j], 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);

    // Constant high input, then a rise exactly on the close cycle.
    do_reset;
    repeat (24) cyc(1'b1, 1'b1);
    for (int j = 0; j < 16; j++) cyc(j % 8 == 7, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);

    // Reset mid-window with a result pending and a partial count.
    do_reset;
    repeat (8) cyc(1'b0, 1'b0);
    for (int j = 0; j < 6; j++) cyc(j % 2 == 0, 1'b0);
    do_reset;
    for (int j = 0; j < 12; j++) cyc(j % 3 == 0, 1'b1);
    repeat (40) cyc(1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset;
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    repeat (2) cyc(1'b0, 1'b1);
    for (int k = 0; k < NDUT; k++) check("handshakes_seen", k, 32'(hs[k] > 10), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
